// File: rtl/calc_pkg.sv
// Definitions shared by the keypad scanner and the calculator sequencing logic:
// operator codes, scanner states and the physical key map.
package calc_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      MUL = 2'b10,
      DIV = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      EMIT,
      RELEASE
   } kp_state_e;

   // Key codes: 0-9 digits, 10-13 operators A-D, 14 '*', 15 '#'; indexed [row][col].
   localparam logic [3:0] KEY_OP_BASE = 4'd10;
   localparam logic [3:0] KEY_STAR    = 4'd14;
   localparam logic [3:0] KEY_HASH    = 4'd15;
   localparam logic [3:0][3:0][3:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

   // Operator keys A-D are consecutive codes, so the op code is the offset from A.
   function automatic op_e key_to_op(input logic [3:0] code);
      return op_e'(code[1:0] - KEY_OP_BASE[1:0]);
   endfunction

endpackage

// File: rtl/kp_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so that
// idle pulled-up lines read as inactive.
module kp_sync #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: walks the columns, debounces press and release, and emits
// a single classified pulse per physical key press.
module keypad_scanner
   import calc_pkg::*;
#(
   parameter int SCAN_DIV     = 1000,
   parameter int DEBOUNCE_CNT = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic       is_num,
   output logic       is_op,
   output logic       is_eq,
   output logic       is_clr,
   output logic [3:0] num_val,
   output logic [1:0] op_val
);

   localparam int SCAN_W = $clog2(SCAN_DIV) + 1;
   localparam int DEB_W  = $clog2(DEBOUNCE_CNT) + 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

   kp_state_e         state, state_next;
   logic [1:0]        col_idx, col_next;
   logic [1:0]        key_row, key_row_next;
   logic [SCAN_W-1:0] scan_cnt, scan_next;
   logic [DEB_W-1:0]  deb_cnt, deb_next;
   logic [3:0]        row_sync;
   logic [1:0]        low_row;
   logic              any_low;
   logic [3:0]        key_code;

   kp_sync #(.WIDTH(4)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_in),
      .q   (row_sync)
   );

   assign col_out  = ~(4'b0001 << col_idx);
   assign any_low  = ~&row_sync;
   assign key_code = KEY_MAP[key_row][col_idx];

   // Lowest row index wins when several rows in the driven column read low.
   always_comb begin
      low_row = 2'd3;
      if (!row_sync[0])      low_row = 2'd0;
      else if (!row_sync[1]) low_row = 2'd1;
      else if (!row_sync[2]) low_row = 2'd2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= SCAN;
         col_idx  <= 2'd0;
         key_row  <= 2'd0;
         scan_cnt <= '0;
         deb_cnt  <= '0;
      end else begin
         state    <= state_next;
         col_idx  <= col_next;
         key_row  <= key_row_next;
         scan_cnt <= scan_next;
         deb_cnt  <= deb_next;
      end
   end

   // Counters compare with >= against their last value, so they can never run
   // past their terminal count or wrap.
   always_comb begin
      state_next   = state;
      col_next     = col_idx;
      key_row_next = key_row;
      scan_next    = scan_cnt;
      deb_next     = deb_cnt;
      unique case (state)
         SCAN: begin
            if (scan_cnt >= SCAN_LAST) begin
               scan_next = '0;
               if (any_low) begin
                  key_row_next = low_row;
                  deb_next     = '0;
                  state_next   = DEBOUNCE;
               end else begin
                  col_next = col_idx + 2'd1;
               end
            end else begin
               scan_next = scan_cnt + SCAN_W'(1);
            end
         end
         DEBOUNCE: begin
            if (row_sync[key_row]) begin
               deb_next   = '0;
               scan_next  = '0;
               col_next   = col_idx + 2'd1;
               state_next = SCAN;
            end else if (deb_cnt >= DEB_LAST) begin
               deb_next   = '0;
               state_next = EMIT;
            end else begin
               deb_next = deb_cnt + DEB_W'(1);
            end
         end
         EMIT: begin
            deb_next   = '0;
            state_next = RELEASE;
         end
         RELEASE: begin
            if (any_low) begin
               deb_next = '0;
            end else if (deb_cnt >= DEB_LAST) begin
               deb_next   = '0;
               scan_next  = '0;
               col_next   = col_idx + 2'd1;
               state_next = SCAN;
            end else begin
               deb_next = deb_cnt + DEB_W'(1);
            end
         end
         default: state_next = SCAN;
      endcase
   end

   always_comb begin
      is_num  = 1'b0;
      is_op   = 1'b0;
      is_eq   = 1'b0;
      is_clr  = 1'b0;
      num_val = 4'd0;
      op_val  = 2'd0;
      if (state == EMIT) begin
         if (key_code <= 4'd9) begin
            is_num  = 1'b1;
            num_val = key_code;
         end else if (key_code == KEY_STAR) begin
            is_clr = 1'b1;
         end else if (key_code == KEY_HASH) begin
            is_eq = 1'b1;
         end else begin
            is_op  = 1'b1;
            op_val = key_to_op(key_code);
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a pin-level keypad model driven from a
// pressed-key mask, with event counters sampled on the falling clock edge.
module tb_keypad_scanner;

   localparam int SCAN_DIV     = 4;
   localparam int DEBOUNCE_CNT = 8;
   localparam int LAT_MAX      = 2 + 4 * SCAN_DIV + DEBOUNCE_CNT + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic       is_num, is_op, is_eq, is_clr;
   logic [3:0] num_val;
   logic [1:0] op_val;
   logic [15:0] pressed = '0;

   int checks   = 0;
   int failures = 0;
   int n_num = 0, n_op = 0, n_eq = 0, n_clr = 0, n_viol = 0;
   logic [3:0] last_num = '0;
   logic [1:0] last_op  = '0;

   typedef struct {
      int row;
      int col;
      bit op;
      int val;
   } vec_t;

   vec_t vecs[4] = '{
      '{row: 3, col: 1, op: 1'b0, val: 0},
      '{row: 0, col: 3, op: 1'b1, val: 0},
      '{row: 3, col: 3, op: 1'b1, val: 3},
      '{row: 0, col: 2, op: 1'b0, val: 3}
   };

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .row_in  (row_in),
      .col_out (col_out),
      .is_num  (is_num),
      .is_op   (is_op),
      .is_eq   (is_eq),
      .is_clr  (is_clr),
      .num_val (num_val),
      .op_val  (op_val)
   );

   // A pressed key pulls its row low only while its column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (is_num) begin n_num++; last_num = num_val; end
      if (is_op)  begin n_op++;  last_op  = op_val;  end
      if (is_eq)  n_eq++;
      if (is_clr) n_clr++;
      if ((int'(is_num) + int'(is_op) + int'(is_eq) + int'(is_clr)) > 1) n_viol++;
      if ((!is_num && num_val != 4'd0) || (!is_op && op_val != 2'd0)) n_viol++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int total_events();
      return n_num + n_op + n_eq + n_clr;
   endfunction

   function automatic logic [15:0] key_mask(input int r, input int c);
      return 16'(1) << (r * 4 + c);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic waitEvent(input int limit, output int lat);
      int base;
      base = total_events();
      lat  = -1;
      for (int i = 1; i <= limit && lat < 0; i++) begin
         waitClocks(1);
         if (total_events() != base) lat = i;
      end
   endtask

   task automatic waitCol(input logic [3:0] target, input int run_len, input int limit, output bit ok);
      int run;
      run = 0;
      ok  = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         waitClocks(1);
         if (col_out == target) run++;
         else run = 0;
         if (run == run_len) ok = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic [15:0] keys, input int hold, input int gap);
      pressed = keys;
      waitClocks(hold);
      pressed = '0;
      waitClocks(gap);
   endtask

   initial begin
      int lat, base, base_k, hold_left;
      bit ok;

      $display("[TB] keypad_scanner bench start");
      #2 rst = 1'b0;
      waitClocks(3);
      checkOutput("reset_col_out", 32'(col_out), 32'(4'b1110));
      checkOutput("reset_events", 32'({is_num, is_op, is_eq, is_clr}), 32'd0);
      checkOutput("reset_num_val", 32'(num_val), 32'd0);
      checkOutput("reset_op_val", 32'(op_val), 32'd0);
      rst = 1'b1;
      waitClocks(1);
      checkOutput("scan_col0_held", 32'(col_out), 32'(4'b1110));
      waitClocks(3);
      checkOutput("scan_col1_after_div", 32'(col_out), 32'(4'b1101));

      // '7' held for 100 clocks
      base = total_events();
      base_k = n_num;
      pressed = key_mask(2, 0);
      waitEvent(40, lat);
      checkOutput("key7_latency_ok", 32'(lat >= 1 && lat <= LAT_MAX), 32'd1);
      checkOutput("key7_pulses", 32'(n_num - base_k), 32'd1);
      checkOutput("key7_num_val", 32'(last_num), 32'd7);
      hold_left = (lat > 0) ? 100 - lat : 100;
      waitClocks(hold_left);
      checkOutput("key7_no_repeat", 32'(total_events() - base), 32'd1);
      pressed = '0;
      waitClocks(40);
      checkOutput("key7_after_release", 32'(total_events() - base), 32'd1);

      // 'B' with three 3-clock bounce glitches, then a steady hold
      base = total_events();
      base_k = n_op;
      repeat (3) begin
         pressed = key_mask(1, 3);
         waitClocks(3);
         pressed = '0;
         waitClocks(3);
      end
      checkOutput("keyB_glitch_no_pulse", 32'(total_events() - base), 32'd0);
      applyStimulus(key_mask(1, 3), 80, 40);
      checkOutput("keyB_op_pulses", 32'(n_op - base_k), 32'd1);
      checkOutput("keyB_op_val", 32'(last_op), 32'd1);
      checkOutput("keyB_total", 32'(total_events() - base), 32'd1);

      // '#' then '*'
      base = total_events();
      base_k = n_eq;
      applyStimulus(key_mask(3, 2), 60, 40);
      checkOutput("hash_eq_pulses", 32'(n_eq - base_k), 32'd1);
      checkOutput("hash_total", 32'(total_events() - base), 32'd1);
      base_k = n_clr;
      applyStimulus(key_mask(3, 0), 60, 40);
      checkOutput("star_clr_pulses", 32'(n_clr - base_k), 32'd1);
      checkOutput("star_total", 32'(total_events() - base), 32'd2);

      // '1' and '4' together in column 0: row 0 wins
      base = total_events();
      base_k = n_num;
      applyStimulus(key_mask(0, 0) | key_mask(1, 0), 60, 40);
      checkOutput("dual_num_pulses", 32'(n_num - base_k), 32'd1);
      checkOutput("dual_num_val", 32'(last_num), 32'd1);
      checkOutput("dual_total", 32'(total_events() - base), 32'd1);

      // Reset asserted while '5' is debouncing
      base = total_events();
      pressed = key_mask(1, 1);
      waitCol(4'b1101, 6, 60, ok);
      checkOutput("key5_reached_debounce", 32'(ok), 32'd1);
      rst = 1'b0;
      waitClocks(2);
      checkOutput("key5_reset_col", 32'(col_out), 32'(4'b1110));
      pressed = '0;
      waitClocks(2);
      rst = 1'b1;
      #1;
      checkOutput("key5_col_after_reset", 32'(col_out), 32'(4'b1110));
      waitClocks(20);
      checkOutput("key5_aborted_no_pulse", 32'(total_events() - base), 32'd0);
      base_k = n_num;
      applyStimulus(key_mask(1, 1), 60, 40);
      checkOutput("key5_fresh_pulses", 32'(n_num - base_k), 32'd1);
      checkOutput("key5_fresh_val", 32'(last_num), 32'd5);

      // '9' released after 5 clocks of debounce
      base = total_events();
      pressed = key_mask(2, 2);
      waitCol(4'b1011, 5, 60, ok);
      checkOutput("key9_reached_debounce", 32'(ok), 32'd1);
      waitClocks(3);
      pressed = '0;
      for (int i = 0; i < 10 && col_out == 4'b1011; i++) waitClocks(1);
      checkOutput("key9_col_advance", 32'(col_out), 32'(4'b0111));
      waitClocks(20);
      checkOutput("key9_no_pulse", 32'(total_events() - base), 32'd0);

      // Remaining digit and operator boundary keys
      foreach (vecs[i]) begin
         base = total_events();
         base_k = vecs[i].op ? n_op : n_num;
         applyStimulus(key_mask(vecs[i].row, vecs[i].col), 60, 40);
         checkOutput($sformatf("tbl%0d_pulses", i),
                     32'((vecs[i].op ? n_op : n_num) - base_k), 32'd1);
         checkOutput($sformatf("tbl%0d_val", i),
                     vecs[i].op ? 32'(last_op) : 32'(last_num), 32'(vecs[i].val));
         checkOutput($sformatf("tbl%0d_total", i), 32'(total_events() - base), 32'd1);
      end

      checkOutput("exclusive_outputs", 32'(n_viol), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
